// File: rtl/control_code_generator4.sv
// Stage-4 control of the pipelined RISC core: registers the stage-3 control word, owns the
// flag register, resolves conditional transfers and sequences the wrong-path flush.
module control_code_generator4 #(
  parameter int FLUSH_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] opcode_in,
  input  logic       E_R0_in,
  input  logic       E_RN_in,
  input  logic       XR0_in,
  input  logic       SOD_in,
  input  logic       EFL_in,
  input  logic       S_AL_in,
  input  logic       LPC_in,
  input  logic [3:0] alu_flags_in,
  input  logic       hold,
  output logic [7:0] opcode_s4,
  output logic       wr_r0,
  output logic       wr_rn,
  output logic       xr0_s4,
  output logic       sod_s4,
  output logic       sel_alu,
  output logic [3:0] flags,
  output logic       take_branch,
  output logic       load_pc,
  output logic       flush
);

  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

  // The first flush cycle is the branch cycle itself, so the counter covers the remaining ones.
  localparam int         CNT_INIT_I = (FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0;
  localparam logic [3:0] CNT_INIT   = CNT_INIT_I[3:0];

  logic [7:0] r_opcode_s4;
  logic       r_valid_s4;
  logic       r_e_r0_s4;
  logic       r_e_rn_s4;
  logic       r_xr0_s4;
  logic       r_sod_s4;
  logic       r_efl_s4;
  logic       r_sal_s4;
  logic       r_lpc_s4;
  logic [3:0] r_flags;
  state_t     r_state;
  logic [3:0] r_cnt;

  logic       w_cond;
  logic       w_take;
  logic       w_flush;

  // Flag order is {S,Z,P,C}; bit 0 of the selector inverts the tested flag.
  function automatic logic cond_met(input logic [2:0] sel, input logic [3:0] fl);
    logic bit_v;
    case (sel[2:1])
      2'b00:   bit_v = fl[0];
      2'b01:   bit_v = fl[2];
      2'b10:   bit_v = fl[3];
      default: bit_v = fl[1];
    endcase
    return bit_v ^ sel[0];
  endfunction

  assign w_cond  = cond_met(r_opcode_s4[2:0], r_flags);
  assign w_take  = r_valid_s4 & r_efl_s4 & r_lpc_s4 & w_cond & ~hold & (r_state == ST_IDLE);
  assign w_flush = (r_state == ST_FLUSH) | w_take;

  // ---- stage 3 -> stage 4 boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode_s4 <= 8'h00;
      r_valid_s4  <= 1'b0;
      r_e_r0_s4   <= 1'b0;
      r_e_rn_s4   <= 1'b0;
      r_xr0_s4    <= 1'b0;
      r_sod_s4    <= 1'b0;
      r_efl_s4    <= 1'b0;
      r_sal_s4    <= 1'b0;
      r_lpc_s4    <= 1'b0;
    end else if (!hold) begin
      r_valid_s4 <= ~w_flush;
      if (w_flush) begin
        r_opcode_s4 <= 8'h00;
        r_e_r0_s4   <= 1'b0;
        r_e_rn_s4   <= 1'b0;
        r_xr0_s4    <= 1'b0;
        r_sod_s4    <= 1'b0;
        r_efl_s4    <= 1'b0;
        r_sal_s4    <= 1'b0;
        r_lpc_s4    <= 1'b0;
      end else begin
        r_opcode_s4 <= opcode_in;
        r_e_r0_s4   <= E_R0_in;
        r_e_rn_s4   <= E_RN_in;
        r_xr0_s4    <= XR0_in;
        r_sod_s4    <= SOD_in;
        r_efl_s4    <= EFL_in;
        r_sal_s4    <= S_AL_in;
        r_lpc_s4    <= LPC_in;
      end
    end
  end

  // Flags follow the instruction entering s4, so a conditional sees its predecessor's result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 4'b0000;
    end else if (!hold && !w_flush && S_AL_in) begin
      r_flags <= alu_flags_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else if (!hold) begin
      case (r_state)
        ST_IDLE: begin
          if (w_take && (FLUSH_CYCLES > 1)) begin
            r_state <= ST_FLUSH;
            r_cnt   <= CNT_INIT;
          end
        end
        ST_FLUSH: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign opcode_s4   = r_opcode_s4;
  assign wr_r0       = r_valid_s4 & r_e_r0_s4 & ~hold;
  assign wr_rn       = r_valid_s4 & r_e_rn_s4 & ~hold;
  assign xr0_s4      = r_xr0_s4;
  assign sod_s4      = r_sod_s4;
  assign sel_alu     = r_sal_s4;
  assign flags       = r_flags;
  assign take_branch = w_take;
  assign load_pc     = w_take;
  assign flush       = w_flush;

endmodule

// File: tb/tb_control_code_generator4.sv
// Directed bench for control_code_generator4: vector table for pipeline/branch behaviour,
// hand sequences for reset, hold during flush, and a full condition-table sweep.
module tb_control_code_generator4;

  logic       clk;
  logic       rst_n;
  logic [7:0] opcode_in;
  logic       E_R0_in, E_RN_in, XR0_in, SOD_in, EFL_in, S_AL_in, LPC_in;
  logic [3:0] alu_flags_in;
  logic       hold;
  logic [7:0] opcode_s4;
  logic       wr_r0, wr_rn, xr0_s4, sod_s4, sel_alu;
  logic [3:0] flags;
  logic       take_branch, load_pc, flush;

  int total = 0;
  int bad   = 0;

  control_code_generator4 #(.FLUSH_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode_in(opcode_in),
    .E_R0_in(E_R0_in), .E_RN_in(E_RN_in), .XR0_in(XR0_in), .SOD_in(SOD_in),
    .EFL_in(EFL_in), .S_AL_in(S_AL_in), .LPC_in(LPC_in),
    .alu_flags_in(alu_flags_in), .hold(hold),
    .opcode_s4(opcode_s4), .wr_r0(wr_r0), .wr_rn(wr_rn), .xr0_s4(xr0_s4),
    .sod_s4(sod_s4), .sel_alu(sel_alu), .flags(flags),
    .take_branch(take_branch), .load_pc(load_pc), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] op;
    logic       er0, ern, xr0, sod, efl, sal, lpc;
    logic [3:0] af;
    logic       hld;
    logic [7:0] x_op;
    logic       x_wr0, x_wrn, x_xr0, x_sod, x_sel;
    logic [3:0] x_fl;
    logic       x_tb, x_fls;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic er0, input logic ern,
                       input logic xr0, input logic sod, input logic efl,
                       input logic sal, input logic lpc, input logic [3:0] af,
                       input logic hld);
    opcode_in = op; E_R0_in = er0; E_RN_in = ern; XR0_in = xr0; SOD_in = sod;
    EFL_in = efl; S_AL_in = sal; LPC_in = lpc; alu_flags_in = af; hold = hld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".opcode"}, 32'(opcode_s4), 32'h0);
    chk({tag, ".ctl"}, 32'({wr_r0, wr_rn, xr0_s4, sod_s4, sel_alu}), 32'h0);
    chk({tag, ".flags"}, 32'(flags), 32'h0);
    chk({tag, ".branch"}, 32'({take_branch, load_pc, flush}), 32'h0);
  endtask

  function automatic logic exp_cond(input int sel, input logic [3:0] f);
    logic s, z, p, c;
    s = f[3]; z = f[2]; p = f[1]; c = f[0];
    case (sel)
      0: return c;
      1: return !c;
      2: return z;
      3: return !z;
      4: return s;
      5: return !s;
      6: return p;
      default: return !p;
    endcase
  endfunction

  initial begin
    // inputs ............................................. expected after the edge
    tbl[0]  = '{8'h81,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,4'b0100,1'b0, 8'h81,1'b1,1'b0,1'b1,1'b0,1'b1,4'b0100,1'b0,1'b0};
    tbl[1]  = '{8'h2A,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,4'b0000,1'b0, 8'h2A,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0100,1'b1,1'b1};
    tbl[2]  = '{8'h81,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,4'b0000,1'b0, 8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0100,1'b0,1'b1};
    tbl[3]  = '{8'h81,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,4'b0000,1'b0, 8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0100,1'b0,1'b1};
    tbl[4]  = '{8'h81,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,4'b0000,1'b0, 8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0100,1'b0,1'b0};
    tbl[5]  = '{8'h81,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,4'b0000,1'b0, 8'h81,1'b1,1'b0,1'b0,1'b0,1'b1,4'b0000,1'b0,1'b0};
    tbl[6]  = '{8'h2A,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,4'b0000,1'b0, 8'h2A,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0};
    tbl[7]  = '{8'h91,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,4'b0001,1'b0, 8'h91,1'b0,1'b1,1'b1,1'b1,1'b1,4'b0001,1'b0,1'b0};
    tbl[8]  = '{8'h28,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,4'b0000,1'b0, 8'h28,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0001,1'b0,1'b0};
    tbl[9]  = '{8'h28,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,4'b0000,1'b0, 8'h28,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0001,1'b1,1'b1};
    tbl[10] = '{8'h2A,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,4'b0000,1'b0, 8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0001,1'b0,1'b1};
    tbl[11] = '{8'h2B,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,4'b0000,1'b0, 8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0001,1'b0,1'b1};
    tbl[12] = '{8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000,1'b0, 8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0001,1'b0,1'b0};
    tbl[13] = '{8'h81,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,4'b1000,1'b0, 8'h81,1'b1,1'b0,1'b0,1'b0,1'b1,4'b1000,1'b0,1'b0};

    rst_n = 1'b0;
    drive(8'h00, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    tick();
    tick();
    chk_zero("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_zero("after_reset");

    // vector table: ALU write, taken/not-taken JCA, squash, LPC=0, branch during flush
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].op, tbl[i].er0, tbl[i].ern, tbl[i].xr0, tbl[i].sod, tbl[i].efl,
            tbl[i].sal, tbl[i].lpc, tbl[i].af, tbl[i].hld);
      tick();
      chk($sformatf("v%0d.opcode", i), 32'(opcode_s4), 32'(tbl[i].x_op));
      chk($sformatf("v%0d.wr_r0", i), 32'(wr_r0), 32'(tbl[i].x_wr0));
      chk($sformatf("v%0d.wr_rn", i), 32'(wr_rn), 32'(tbl[i].x_wrn));
      chk($sformatf("v%0d.xr0_sod", i), 32'({xr0_s4, sod_s4}), 32'({tbl[i].x_xr0, tbl[i].x_sod}));
      chk($sformatf("v%0d.sel_alu", i), 32'(sel_alu), 32'(tbl[i].x_sel));
      chk($sformatf("v%0d.flags", i), 32'(flags), 32'(tbl[i].x_fl));
      chk($sformatf("v%0d.take", i), 32'(take_branch), 32'(tbl[i].x_tb));
      chk($sformatf("v%0d.load_pc", i), 32'(load_pc), 32'(tbl[i].x_tb));
      chk($sformatf("v%0d.flush", i), 32'(flush), 32'(tbl[i].x_fls));
    end

    // hold while a taken conditional sits in s4 in IDLE: no branch until hold drops
    drive(8'h81, 1, 0, 0, 0, 0, 1, 0, 4'b0100, 0);
    tick();
    drive(8'h2A, 0, 0, 0, 0, 1, 0, 1, 4'b0000, 0);
    tick();
    chk("hi.take0", 32'(take_branch), 32'd1);
    drive(8'h81, 1, 1, 0, 0, 0, 1, 0, 4'b0011, 1);
    #1;
    chk("hi.take_held", 32'({take_branch, load_pc, flush}), 32'h0);
    tick();
    chk("hi.opcode_held", 32'(opcode_s4), 32'h2A);
    chk("hi.flags_held", 32'(flags), 32'b0100);
    hold = 1'b0;
    #1;
    chk("hi.take_release", 32'({take_branch, load_pc, flush}), 32'h7);

    // taken branch, then two hold cycles inside FLUSH
    tick();
    chk("hf.enter", 32'({flush, opcode_s4}), 32'({1'b1, 8'h00}));
    hold = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("hf.hold%0d.flush", k), 32'(flush), 32'd1);
      chk($sformatf("hf.hold%0d.wr", k), 32'({wr_r0, wr_rn, take_branch}), 32'h0);
      tick();
      chk($sformatf("hf.hold%0d.flags", k), 32'(flags), 32'b0100);
    end
    hold = 1'b0;
    #1;
    chk("hf.post_hold.flush", 32'(flush), 32'd1);
    tick();
    chk("hf.last.flush", 32'(flush), 32'd1);
    chk("hf.last.opcode", 32'(opcode_s4), 32'h00);
    tick();
    chk("hf.done.flush", 32'(flush), 32'd0);
    chk("hf.done.wr", 32'(wr_r0), 32'd0);
    tick();
    chk("hf.resume.wr", 32'({wr_r0, wr_rn}), 32'b11);
    chk("hf.resume.flags", 32'(flags), 32'b0011);

    // condition table sweep
    for (int fl = 0; fl < 8; fl++) begin
      for (int f = 0; f < 16; f++) begin
        logic [3:0] fv;
        logic [7:0] op;
        logic       want;
        fv   = 4'(f);
        op   = 8'(8'h28 | fl);
        want = exp_cond(fl, fv);
        drive(8'h00, 0, 0, 0, 0, 0, 1, 0, fv, 0);
        tick();
        drive(op, 0, 0, 0, 0, 1, 0, 1, 4'h0, 0);
        tick();
        chk($sformatf("sw.fl%0d.f%0h.take", fl, f), 32'({take_branch, load_pc}), 32'({want, want}));
        drive(8'h00, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
        tick();
        tick();
        tick();
      end
    end

    // reset asserted mid-cycle during a flush with random controls
    drive(8'h00, 0, 0, 0, 0, 0, 1, 0, 4'b0100, 0);
    tick();
    drive(8'h2A, 0, 0, 0, 0, 1, 0, 1, 4'h0, 0);
    tick();
    drive(8'h00, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    tick();
    chk("rm.in_flush", 32'(flush), 32'd1);
    drive(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("rm.async");
    tick();
    chk_zero("rm.held");
    drive(8'h00, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'h81, 1, 0, 0, 0, 0, 1, 0, 4'b0010, 0);
    tick();
    chk("rm.restart", 32'({opcode_s4, wr_r0, flags, flush}), 32'({8'h81, 1'b1, 4'b0010, 1'b0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
